// File: rtl/asip_pkg.sv
`default_nettype none
// ============================================================================
// Module   : asip_pkg
// Purpose  : Shared types for the ASIP pipeline: ALU opcodes, writeback
//            selects and execute-stage FSM states.
// Revision : 1.0
// ============================================================================
package asip_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SHL = 3'd5,
        SHR = 3'd6,
        MUL = 3'd7
    } alu_op_e;

    localparam logic [1:0] WB_FROM_MEM = 2'd0;
    localparam logic [1:0] WB_FROM_ALU = 2'd1;
    localparam logic [1:0] WB_FROM_IMM = 2'd2;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } exec_state_e;

endpackage
`default_nettype wire

// File: rtl/vec_serial_mul.sv
`default_nettype none
// ============================================================================
// Module   : vec_serial_mul
// Purpose  : Lane-serial vector multiplier, one lane product per busy cycle.
// Revision : 1.0
// ============================================================================
module vec_serial_mul #(
    parameter int vecSize      = 4,
    parameter int registerSize = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 busy,
    input  logic [vecSize-1:0][registerSize-1:0] a,
    input  logic [vecSize-1:0][registerSize-1:0] b,
    output logic                                 done,
    output logic [vecSize-1:0][registerSize-1:0] product
);

    localparam int c_CNT_W = (vecSize > 1) ? $clog2(vecSize) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_LANE = c_CNT_W'(vecSize - 1);

    logic [vecSize-1:0][registerSize-1:0] r_a;
    logic [vecSize-1:0][registerSize-1:0] r_b;
    logic [vecSize-1:0][registerSize-1:0] r_prod;
    logic [c_CNT_W-1:0]                   r_cnt;
    logic [registerSize-1:0]              w_lane;

    // Evaluated at lane width, so only the low bits of the product survive.
    assign w_lane = r_a[r_cnt] * r_b[r_cnt];
    assign done   = busy && (r_cnt == c_LAST_LANE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
        end else if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_prod <= '0;
            r_cnt  <= '0;
        end else if (busy) begin
            r_prod[r_cnt] <= w_lane;
            r_cnt         <= r_cnt + c_CNT_W'(1);
        end
    end

    // Final lane is merged combinationally so the full vector is ready on done.
    always_comb begin
        product        = r_prod;
        product[r_cnt] = w_lane;
    end

endmodule
`default_nettype wire

// File: rtl/stage_execute.sv
`default_nettype none
// ============================================================================
// Module   : stage_execute
// Purpose  : Vector execute stage: lane ALU, serial MUL, address/store data.
// Revision : 1.0
// ============================================================================
module stage_execute #(
    parameter int vecSize      = 4,
    parameter int registerSize = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 valid_in,
    output logic                                 ready_out,
    input  logic [2:0]                           aluControl,
    input  logic [vecSize-1:0][registerSize-1:0] srcA,
    input  logic [vecSize-1:0][registerSize-1:0] srcB,
    input  logic [registerSize-1:0]              imm,
    input  logic [1:0]                           writeRegFrom_in,
    input  logic                                 writeEnable_in,
    output logic                                 valid_out,
    output logic [vecSize-1:0][registerSize-1:0] aluResult,
    output logic [vecSize-1:0][registerSize-1:0] writeData,
    output logic [registerSize-1:0]              address,
    output logic [registerSize-1:0]              imm_out,
    output logic [1:0]                           writeRegFrom,
    output logic                                 writeEnable
);
    import asip_pkg::*;

    localparam int c_SH_W = (registerSize > 1) ? $clog2(registerSize) : 1;

    exec_state_e                          r_state;
    exec_state_e                          w_stateNext;
    alu_op_e                              w_op;
    logic                                 w_accept;
    logic                                 w_mulStart;
    logic                                 w_mulDone;
    logic [c_SH_W-1:0]                    w_shamt;
    logic [registerSize-1:0]              w_addr;
    logic [vecSize-1:0][registerSize-1:0] w_aluVec;
    logic [vecSize-1:0][registerSize-1:0] w_mulVec;

    // Side-band of the in-flight MUL, released together with its result.
    logic [vecSize-1:0][registerSize-1:0] r_pendData;
    logic [registerSize-1:0]              r_pendAddr;
    logic [registerSize-1:0]              r_pendImm;
    logic [1:0]                           r_pendWrf;
    logic                                 r_pendWe;

    assign w_op    = alu_op_e'(aluControl);
    assign w_shamt = imm[c_SH_W-1:0];
    assign w_addr  = srcA[0] + imm;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        ready_out   = 1'b0;
        w_accept    = 1'b0;
        w_mulStart  = 1'b0;
        case (r_state)
            IDLE: begin
                ready_out  = 1'b1;
                w_accept   = valid_in;
                w_mulStart = valid_in && (w_op == MUL);
                if (w_mulStart) w_stateNext = MUL_BUSY;
            end
            MUL_BUSY: begin
                if (w_mulDone) w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_aluVec = '0;
        for (int i = 0; i < vecSize; i++) begin
            case (w_op)
                ADD:     w_aluVec[i] = srcA[i] + srcB[i];
                SUB:     w_aluVec[i] = srcA[i] - srcB[i];
                AND:     w_aluVec[i] = srcA[i] & srcB[i];
                OR:      w_aluVec[i] = srcA[i] | srcB[i];
                XOR:     w_aluVec[i] = srcA[i] ^ srcB[i];
                SHL:     w_aluVec[i] = srcA[i] << w_shamt;
                SHR:     w_aluVec[i] = srcA[i] >> w_shamt;
                default: w_aluVec[i] = '0;
            endcase
        end
    end

    vec_serial_mul #(
        .vecSize      (vecSize),
        .registerSize (registerSize)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mulStart),
        .busy    (r_state == MUL_BUSY),
        .a       (srcA),
        .b       (srcB),
        .done    (w_mulDone),
        .product (w_mulVec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_out    <= 1'b0;
            aluResult    <= '0;
            writeData    <= '0;
            address      <= '0;
            imm_out      <= '0;
            writeRegFrom <= '0;
            writeEnable  <= 1'b0;
            r_pendData   <= '0;
            r_pendAddr   <= '0;
            r_pendImm    <= '0;
            r_pendWrf    <= '0;
            r_pendWe     <= 1'b0;
        end else begin
            valid_out   <= 1'b0;
            writeEnable <= 1'b0;
            if (w_accept && !w_mulStart) begin
                valid_out    <= 1'b1;
                aluResult    <= w_aluVec;
                writeData    <= srcB;
                address      <= w_addr;
                imm_out      <= imm;
                writeRegFrom <= writeRegFrom_in;
                writeEnable  <= writeEnable_in;
            end else if (w_mulDone) begin
                valid_out    <= 1'b1;
                aluResult    <= w_mulVec;
                writeData    <= r_pendData;
                address      <= r_pendAddr;
                imm_out      <= r_pendImm;
                writeRegFrom <= r_pendWrf;
                writeEnable  <= r_pendWe;
            end
            if (w_mulStart) begin
                r_pendData <= srcB;
                r_pendAddr <= w_addr;
                r_pendImm  <= imm;
                r_pendWrf  <= writeRegFrom_in;
                r_pendWe   <= writeEnable_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_execute.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_execute
// Purpose  : Scoreboard bench for stage_execute (vecSize=4, registerSize=8).
// Revision : 1.0
// ============================================================================
module tb_stage_execute;
    import asip_pkg::*;

    localparam int c_VEC = 4;
    localparam int c_W   = 8;

    typedef logic [c_VEC-1:0][c_W-1:0] vec_t;
    typedef struct {
        vec_t       alu;
        vec_t       wd;
        logic [7:0] addr;
        logic [7:0] imm;
        logic [1:0] wrf;
        logic       we;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic [2:0] aluControl = 3'd0;
    vec_t       srcA = '0;
    vec_t       srcB = '0;
    logic [7:0] imm = 8'd0;
    logic [1:0] writeRegFrom_in = 2'd0;
    logic       writeEnable_in = 1'b0;
    logic       valid_out;
    vec_t       aluResult;
    vec_t       writeData;
    logic [7:0] address;
    logic [7:0] imm_out;
    logic [1:0] writeRegFrom;
    logic       writeEnable;

    int   nChecks = 0;
    int   nPass = 0;
    exp_t q[$];

    stage_execute #(.vecSize(c_VEC), .registerSize(c_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .aluControl      (aluControl),
        .srcA            (srcA),
        .srcB            (srcB),
        .imm             (imm),
        .writeRegFrom_in (writeRegFrom_in),
        .writeEnable_in  (writeEnable_in),
        .valid_out       (valid_out),
        .aluResult       (aluResult),
        .writeData       (writeData),
        .address         (address),
        .imm_out         (imm_out),
        .writeRegFrom    (writeRegFrom),
        .writeEnable     (writeEnable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic vec_t vec(input logic [7:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // Independent lane-wise reference for every opcode.
    function automatic vec_t model(input logic [2:0] op, input vec_t a, input vec_t b, input logic [7:0] sh);
        vec_t r;
        int   p;
        for (int i = 0; i < c_VEC; i++) begin
            case (op)
                3'd0: r[i] = a[i] + b[i];
                3'd1: r[i] = a[i] - b[i];
                3'd2: r[i] = a[i] & b[i];
                3'd3: r[i] = a[i] | b[i];
                3'd4: r[i] = a[i] ^ b[i];
                3'd5: r[i] = a[i] << sh[2:0];
                3'd6: r[i] = a[i] >> sh[2:0];
                default: begin
                    p    = int'(a[i]) * int'(b[i]);
                    r[i] = p[7:0];
                end
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (valid_out) begin
            if (q.size() == 0) begin
                check("unexpected valid_out", 64'(valid_out), 64'd0);
            end else begin
                e = q.pop_front();
                check("aluResult", 64'(aluResult), 64'(e.alu));
                check("writeData", 64'(writeData), 64'(e.wd));
                check("address", 64'(address), 64'(e.addr));
                check("imm_out", 64'(imm_out), 64'(e.imm));
                check("writeRegFrom", 64'(writeRegFrom), 64'(e.wrf));
                check("writeEnable", 64'(writeEnable), 64'(e.we));
            end
        end else begin
            check("bubble writeEnable", 64'(writeEnable), 64'd0);
        end
    end

    // Holds the instruction until accepted; returns at the negedge after the transfer edge.
    task automatic present(input logic [2:0] op, input vec_t a, input vec_t b, input logic [7:0] im,
                           input logic [1:0] wrf, input logic we, input bit track, output int waits);
        exp_t e;
        aluControl      = op;
        srcA            = a;
        srcB            = b;
        imm             = im;
        writeRegFrom_in = wrf;
        writeEnable_in  = we;
        valid_in        = 1'b1;
        waits           = 0;
        while (!ready_out && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!ready_out) begin
            check("accept timeout", 64'd0, 64'd1);
        end else if (track) begin
            e.alu  = model(op, a, b, im);
            e.wd   = b;
            e.addr = a[0] + im;
            e.imm  = im;
            e.wrf  = wrf;
            e.we   = we;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int   w;
        vec_t ra;
        vec_t rb;

        repeat (2) @(negedge clk);
        check("reset valid_out", 64'(valid_out), 64'd0);
        check("reset ready_out", 64'(ready_out), 64'd1);
        check("reset aluResult", 64'(aluResult), 64'd0);
        check("reset address", 64'(address), 64'd0);
        check("reset writeEnable", 64'(writeEnable), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        present(3'd0, vec(1, 2, 3, 4), vec(10, 20, 30, 40), 8'd0, WB_FROM_ALU, 1'b0, 1'b1, w);
        check("add valid", 64'(valid_out), 64'd1);
        check("add lanes", 64'(aluResult), 64'h2C21160B);
        idle(1);
        check("add one-shot", 64'(valid_out), 64'd0);

        present(3'd1, vec(0, 0, 0, 0), vec(1, 1, 1, 1), 8'd0, WB_FROM_ALU, 1'b0, 1'b1, w);
        check("sub wrap", 64'(aluResult), 64'hFFFFFFFF);
        present(3'd5, vec(8'h81, 8'h40, 8'h01, 8'hFF), vec(0, 0, 0, 0), 8'd1, WB_FROM_ALU, 1'b0, 1'b1, w);
        check("shl lane0", 64'(aluResult[0]), 64'h02);
        check("shl valid b2b", 64'(valid_out), 64'd1);

        for (int k = 0; k < 10; k++) begin
            ra = vec_t'($urandom);
            rb = vec_t'($urandom);
            present(3'($urandom_range(0, 6)), ra, rb, 8'($urandom), 2'($urandom_range(0, 2)),
                    1'($urandom), 1'b1, w);
        end
        idle(1);

        present(3'd0, vec(8'h10, 0, 0, 0), vec(7, 8, 9, 10), 8'h05, WB_FROM_MEM, 1'b1, 1'b1, w);
        check("store address", 64'(address), 64'h15);
        check("store data", 64'(writeData), 64'h0A090807);
        check("store we", 64'(writeEnable), 64'd1);
        idle(1);
        check("store we one-shot", 64'(writeEnable), 64'd0);

        present(3'd0, vec(8'hF0, 0, 0, 0), vec(0, 0, 0, 0), 8'h20, WB_FROM_IMM, 1'b0, 1'b1, w);
        check("address wrap", 64'(address), 64'h10);
        idle(1);

        present(3'd7, vec(3, 4, 16, 255), vec(5, 6, 16, 2), 8'd0, WB_FROM_ALU, 1'b0, 1'b1, w);
        valid_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("mul ready low", 64'(ready_out), 64'd0);
            check("mul valid low", 64'(valid_out), 64'd0);
            @(negedge clk);
        end
        check("mul valid", 64'(valid_out), 64'd1);
        check("mul ready back", 64'(ready_out), 64'd1);
        check("mul lanes", 64'(aluResult), 64'hFE00180F);
        idle(1);

        present(3'd7, vec(9, 10, 11, 12), vec(2, 3, 4, 5), 8'd3, WB_FROM_ALU, 1'b1, 1'b1, w);
        present(3'd0, vec(5, 6, 7, 8), vec(1, 1, 1, 1), 8'd0, WB_FROM_ALU, 1'b0, 1'b1, w);
        check("stall cycles", 64'(w), 64'd4);
        check("add after mul valid", 64'(valid_out), 64'd1);
        idle(2);

        present(3'd7, vec(1, 2, 3, 4), vec(1, 2, 3, 4), 8'd0, WB_FROM_ALU, 1'b1, 1'b0, w);
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        check("abort aluResult", 64'(aluResult), 64'd0);
        check("abort writeData", 64'(writeData), 64'd0);
        check("abort valid", 64'(valid_out), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort ready", 64'(ready_out), 64'd1);
        for (int k = 0; k < 6; k++) begin
            check("abort no valid", 64'(valid_out), 64'd0);
            @(negedge clk);
        end

        present(3'd0, vec(1, 2, 3, 4), vec(10, 20, 30, 40), 8'd0, WB_FROM_ALU, 1'b0, 1'b1, w);
        check("post-abort add", 64'(aluResult), 64'h2C21160B);
        idle(3);
        check("scoreboard drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
